sync_spram_param: RTL and testbench
===================================

SYNC_SPRAM_PARAM -- requirements
Module: sync_spram_param

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data word width; it is a multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 8, number of words; it is at least 2 and need not be a power of 2.
REQ-003 SHALL have parameter ADDR_W, default 3, address width, equal to ceil(log2(DEPTH)).
REQ-004 SHALL have parameter RD_LAT, default 1, read latency in cycles; legal values are 1 and 2.
REQ-005 SHALL have parameter CLR_ON_RST, default 1; 1 means memory is zero-filled after reset, 0 means memory contents are retained.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port we, input, 1 bit: write request.
REQ-009 SHALL have port re, input, 1 bit: read request.
REQ-010 SHALL have port addr, input, ADDR_W bits: word address shared by read and write.
REQ-011 SHALL have port be, input, DATA_W/8 bits: byte write enables; be[i] covers bits 8i+7..8i.
REQ-012 SHALL have port datainout, inout, DATA_W bits: shared bidirectional data bus.
REQ-013 SHALL have port rvalid, output, 1 bit: high for exactly one cycle per read result.
REQ-014 SHALL have port busy, output, 1 bit: high while the clear sequence runs; requests are ignored while it is high.
REQ-015 SHALL have port err, output, 1 bit: one-cycle pulse flagging a rejected request.

Function
REQ-016 SHALL implement a two-state FSM, CLEAR and IDLE, with a clear counter of width ADDR_W.
- CLEAR: write 0 to mem[clr_cnt] and increment clr_cnt.
- CLEAR to IDLE: on the cycle clr_cnt equals DEPTH-1.
- Duration: the clear takes exactly DEPTH cycles.
REQ-017 SHALL drive busy = 1 exactly while in CLEAR; we and re are ignored then, and no err is raised.
REQ-018 SHALL perform a write in IDLE when we=1, re=0, addr<DEPTH and no read data is on the bus.
- Each byte i with be[i]=1 is written from datainout.
- Bytes with be[i]=0 keep their value.
- be = 0 is a legal no-op write.
REQ-019 SHALL issue a read in IDLE when re=1, we=0 and addr<DEPTH.
- mem[addr] is presented on datainout with rvalid=1 exactly RD_LAT cycles after the request edge.
REQ-020 SHALL accept one read per cycle; back-to-back reads produce back-to-back rvalid pulses with data in request order.
REQ-021 SHALL drive datainout from the read pipeline only while rvalid=1, and hold it at high impedance otherwise.
REQ-022 SHALL make a write visible to a read of the same address issued the next cycle; a read issued in the same cycle as a write is not possible (see REQ-023).
REQ-023 SHALL reject the following requests, perform no memory access, and pulse err=1 on the next cycle:
- we=1 and re=1 together;
- addr >= DEPTH with we or re set;
- we=1 in a cycle where rvalid=1 (bus contention; the write is suppressed).
REQ-024 SHALL register err and rvalid; they are never combinational from inputs.
REQ-025 SHALL treat rst as dominant over every request in the same cycle.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, take the following values at that edge:
- rvalid=0, err=0, clr_cnt=0;
- read pipeline registers = 0;
- datainout released to high impedance.
REQ-027 SHALL enter CLEAR with busy=1 on reset when CLR_ON_RST=1, and IDLE with busy=0 and memory untouched when CLR_ON_RST=0.
REQ-028 SHALL flush reads in flight when reset is asserted mid-operation; no rvalid pulse follows for them.
REQ-029 SHALL restart a clear already in progress at address 0 if rst is reasserted during CLEAR.

Verification
REQ-030 Bench SHALL cover reset and clear (defaults): rst high 1 cycle -> busy=1 for exactly 8 cycles, then 0; reading addresses 0..7 returns 0x0000 for each.
REQ-031 Bench SHALL cover write then read: write 0xA5C3 to addr 5 with be=2'b11, read addr 5 on the next cycle -> rvalid=1 with datainout=0xA5C3 after 1 cycle (RD_LAT=1) and after 2 cycles (RD_LAT=2).
REQ-032 Bench SHALL cover byte enables: addr 2 holds 0x1234, write 0xABCD with be=2'b01 -> reads back 0x12CD.
REQ-033 Bench SHALL cover streaming reads: read addrs 1,2,3 on consecutive cycles -> three consecutive rvalid pulses carrying mem[1], mem[2], mem[3]; the bus is high-Z before the first and after the last.
REQ-034 Bench SHALL cover error cases, each giving a one-cycle err pulse with memory unchanged:
- we=1 and re=1 at addr 4;
- DEPTH=6, write to addr 7;
- we=1 in the rvalid cycle.
REQ-035 Bench SHALL cover reset mid-operation: rst during an in-flight read with RD_LAT=2 -> no rvalid; with CLR_ON_RST=0, data written earlier survives the reset.

Source files
------------

// File: rtl/sync_spram_param.sv
// Single-port RAM with byte enables, shared tri-state data bus, 1- or 2-cycle read latency
// and an optional zero-fill sequence after reset; illegal requests are dropped and flagged on err.
module sync_spram_param #(
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3,
  parameter int RD_LAT     = 1,
  parameter bit CLR_ON_RST = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic                re,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W/8-1:0] be,
  inout  wire  [DATA_W-1:0]   datainout,
  output logic                rvalid,
  output logic                busy,
  output logic                err
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_IDLE} state_e;
  localparam state_e RST_STATE = CLR_ON_RST ? S_CLEAR : S_IDLE;

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              p_vld_q, p_vld_d;
  logic [DATA_W-1:0] p_dat_q, p_dat_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdat_q, rdat_d;
  logic              err_q, err_d;

  logic              idle, addr_ok, rd_go, wr_go;
  logic [ADDR_W-1:0] rd_idx;
  logic [DATA_W-1:0] rd_word;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_idx;
  logic [DATA_W-1:0] mem_wdat;

  always_comb begin
    idle    = (state_q == S_IDLE);
    addr_ok = ({1'b0, addr} < DEPTH_X);
    rd_go   = idle && re && !we && addr_ok;
    // A write while read data owns the bus would read back our own output.
    wr_go   = idle && we && !re && addr_ok && !rvalid_q;
    err_d   = idle && ((we && re) || ((we || re) && !addr_ok) || (we && rvalid_q));
    rd_idx  = addr_ok ? addr : '0;
    rd_word = mem_q[rd_idx];

    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (!idle) begin
      clr_cnt_d = clr_cnt_q + ADDR_W'(1);
      if (clr_cnt_q == LAST) begin
        state_d   = S_IDLE;
        clr_cnt_d = '0;
      end
    end

    p_vld_d = rd_go;
    p_dat_d = rd_word;
    if (RD_LAT == 2) begin
      rvalid_d = p_vld_q;
      rdat_d   = p_dat_q;
    end else begin
      rvalid_d = rd_go;
      rdat_d   = rd_word;
    end

    mem_we   = !rst && (wr_go || !idle);
    mem_idx  = idle ? addr : clr_cnt_q;
    mem_wdat = '0;
    if (idle) begin
      for (int i = 0; i < NB; i++) begin
        mem_wdat[8*i +: 8] = be[i] ? datainout[8*i +: 8] : rd_word[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RST_STATE;
      clr_cnt_q <= '0;
      p_vld_q   <= 1'b0;
      p_dat_q   <= '0;
      rvalid_q  <= 1'b0;
      rdat_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      p_vld_q   <= p_vld_d;
      p_dat_q   <= p_dat_d;
      rvalid_q  <= rvalid_d;
      rdat_q    <= rdat_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_idx] <= mem_wdat;
    end
  end

  assign datainout = rvalid_q ? rdat_q : {DATA_W{1'bz}};
  assign rvalid    = rvalid_q;
  assign err       = err_q;
  assign busy      = (state_q == S_CLEAR);

endmodule

// File: tb/tb_sync_spram_param.sv
// Directed bench: instance 0 uses defaults (clear on reset, latency 1); instance 1 has
// DEPTH=6, latency 2 and retains memory across reset. Idle bus lines are pulled high.
module tb_sync_spram_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst, we, re, drv_en;
  logic [2:0]  addr [2];
  logic [1:0]  be [2];
  logic [15:0] drv_dat [2];
  logic [1:0]  rvalid, busy, err;
  tri1  [15:0] bus0, bus1;

  int n_tests = 0;
  int n_fail  = 0;

  assign bus0 = drv_en[0] ? drv_dat[0] : 16'bz;
  assign bus1 = drv_en[1] ? drv_dat[1] : 16'bz;

  sync_spram_param u_a (
    .clk(clk), .rst(rst[0]), .we(we[0]), .re(re[0]), .addr(addr[0]), .be(be[0]),
    .datainout(bus0), .rvalid(rvalid[0]), .busy(busy[0]), .err(err[0])
  );

  sync_spram_param #(
    .DATA_W(16), .DEPTH(6), .ADDR_W(3), .RD_LAT(2), .CLR_ON_RST(1'b0)
  ) u_b (
    .clk(clk), .rst(rst[1]), .we(we[1]), .re(re[1]), .addr(addr[1]), .be(be[1]),
    .datainout(bus1), .rvalid(rvalid[1]), .busy(busy[1]), .err(err[1])
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %04h expected %04h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_in(input bit u);
    we[u] = 1'b0; re[u] = 1'b0; addr[u] = 3'd0; be[u] = 2'b00;
    drv_en[u] = 1'b0; drv_dat[u] = 16'h0000;
  endtask

  function automatic logic [15:0] bus(input bit u);
    return u ? bus1 : bus0;
  endfunction

  task automatic wr(input bit u, input logic [2:0] a, input logic [15:0] d, input logic [1:0] b);
    we[u] = 1'b1; addr[u] = a; be[u] = b; drv_en[u] = 1'b1; drv_dat[u] = d;
    cyc();
    clr_in(u);
  endtask

  task automatic rd_chk(input bit u, input logic [2:0] a, input logic [15:0] exp, input string tag);
    re[u] = 1'b1; addr[u] = a;
    cyc();
    clr_in(u);
    if (u) begin
      chk({tag, " early"}, 16'(rvalid[u]), 16'd0);
      cyc();
    end
    chk({tag, " rvalid"}, 16'(rvalid[u]), 16'd1);
    chk({tag, " data"}, bus(u), exp);
    cyc();
    chk({tag, " rvalid end"}, 16'(rvalid[u]), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    clr_in(1'b0);
    clr_in(1'b1);
    rst = 2'b11;
    cyc();
    rst = 2'b00;
    cyc(8);

    // Fill instance 0 with non-zero data so the clear is observable.
    for (int i = 0; i < 8; i++) wr(1'b0, 3'(i), 16'(16'h1111 * (i + 1)), 2'b11);

    rst[0] = 1'b1;
    cyc();
    rst[0] = 1'b0;
    chk("rst busy", 16'(busy[0]), 16'd1);
    chk("rst rvalid", 16'(rvalid[0]), 16'd0);
    chk("rst err", 16'(err[0]), 16'd0);
    chk("rst bus hiz", bus0, 16'hFFFF);
    for (int i = 1; i < 8; i++) begin
      cyc();
      chk($sformatf("clear busy %0d", i), 16'(busy[0]), 16'd1);
    end
    // Write attempted during the final clear cycle must be ignored silently.
    wr(1'b0, 3'd3, 16'hBEEF, 2'b11);
    chk("clear done", 16'(busy[0]), 16'd0);
    chk("clear no err", 16'(err[0]), 16'd0);
    for (int i = 0; i < 8; i++) rd_chk(1'b0, 3'(i), 16'h0000, $sformatf("clear rd %0d", i));

    wr(1'b0, 3'd5, 16'hA5C3, 2'b11);
    chk("wr a err", 16'(err[0]), 16'd0);
    rd_chk(1'b0, 3'd5, 16'hA5C3, "wr-rd lat1");
    wr(1'b1, 3'd5, 16'hA5C3, 2'b11);
    wr(1'b1, 3'd0, 16'h0F0F, 2'b11);
    rd_chk(1'b1, 3'd5, 16'hA5C3, "wr-rd lat2");

    wr(1'b0, 3'd2, 16'h1234, 2'b11);
    wr(1'b0, 3'd2, 16'hABCD, 2'b01);
    rd_chk(1'b0, 3'd2, 16'h12CD, "byte en");
    wr(1'b0, 3'd2, 16'h5555, 2'b00);
    rd_chk(1'b0, 3'd2, 16'h12CD, "be zero");

    wr(1'b0, 3'd1, 16'h1001, 2'b11);
    wr(1'b0, 3'd3, 16'h3003, 2'b11);
    cyc();
    chk("stream pre hiz", bus0, 16'hFFFF);
    re[0] = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      addr[0] = 3'(i);
      cyc();
      chk($sformatf("stream rvalid %0d", i), 16'(rvalid[0]), 16'd1);
      chk($sformatf("stream data %0d", i), bus0,
          (i == 1) ? 16'h1001 : (i == 2) ? 16'h12CD : 16'h3003);
    end
    clr_in(1'b0);
    cyc();
    chk("stream post rvalid", 16'(rvalid[0]), 16'd0);
    chk("stream post hiz", bus0, 16'hFFFF);

    wr(1'b0, 3'd4, 16'h4444, 2'b11);
    we[0] = 1'b1; re[0] = 1'b1; addr[0] = 3'd4; be[0] = 2'b11;
    drv_en[0] = 1'b1; drv_dat[0] = 16'h9999;
    cyc();
    clr_in(1'b0);
    chk("we+re err", 16'(err[0]), 16'd1);
    chk("we+re no rd", 16'(rvalid[0]), 16'd0);
    cyc();
    chk("we+re err pulse", 16'(err[0]), 16'd0);
    rd_chk(1'b0, 3'd4, 16'h4444, "we+re mem");

    wr(1'b1, 3'd7, 16'hDEAD, 2'b11);
    chk("oob err", 16'(err[1]), 16'd1);
    cyc();
    chk("oob err pulse", 16'(err[1]), 16'd0);
    rd_chk(1'b1, 3'd0, 16'h0F0F, "oob mem0");
    rd_chk(1'b1, 3'd5, 16'hA5C3, "oob mem5");

    re[0] = 1'b1; addr[0] = 3'd4;
    cyc();
    re[0] = 1'b0; we[0] = 1'b1; be[0] = 2'b11;
    chk("contend rvalid", 16'(rvalid[0]), 16'd1);
    chk("contend data", bus0, 16'h4444);
    cyc();
    clr_in(1'b0);
    chk("contend err", 16'(err[0]), 16'd1);
    cyc();
    chk("contend err pulse", 16'(err[0]), 16'd0);
    wr(1'b0, 3'd6, 16'h6666, 2'b11);
    rd_chk(1'b0, 3'd6, 16'h6666, "contend wr ok");
    rd_chk(1'b0, 3'd4, 16'h4444, "contend mem");

    re[1] = 1'b1; addr[1] = 3'd5;
    cyc();
    clr_in(1'b1);
    // Reset wins over a simultaneous write.
    rst[1] = 1'b1; we[1] = 1'b1; addr[1] = 3'd0; be[1] = 2'b11;
    drv_en[1] = 1'b1; drv_dat[1] = 16'hDEAD;
    cyc();
    clr_in(1'b1);
    rst[1] = 1'b0;
    chk("flush rvalid", 16'(rvalid[1]), 16'd0);
    chk("flush busy", 16'(busy[1]), 16'd0);
    chk("flush err", 16'(err[1]), 16'd0);
    cyc();
    chk("flush rvalid +1", 16'(rvalid[1]), 16'd0);
    cyc();
    chk("flush rvalid +2", 16'(rvalid[1]), 16'd0);
    rd_chk(1'b1, 3'd5, 16'hA5C3, "retain mem5");
    rd_chk(1'b1, 3'd0, 16'h0F0F, "retain mem0");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
